cordic_atanh: RTL and testbench

- Iterative hyperbolic CORDIC in vectoring mode.
- Computes the inverse of the tanh activation.
- Takes an 8-bit signed tanh code, as produced by the forward `cordic` block, and returns atanh of it in signed Q8.8, the same format as the forward block's input.
- Sits on the MLP back-path and in the self-check loop: `cordic` → `cordic_atanh` recovers the pre-activation value.

---
 rtl/cordic_atanh_pkg.sv | 30 +++
 rtl/cordic_atanh_if.sv | 19 +
 rtl/cordic_atanh_hyp_stage.sv | 33 +++
 rtl/cordic_atanh.sv | 138 +++++++++++++
 tb/tb_cordic_atanh.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cordic_atanh_pkg.sv
// rtl/cordic_atanh_pkg.sv - shared constants, state type and helpers for the atanh CORDIC
package cordic_pkg;

  localparam int FRAC_BITS  = 14;
  localparam int ONE        = 16384;
  localparam int CLAMP_CODE = 102;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIN
  } state_e;

  // atanh(2^-k) in Q3.14, indexed by shift amount k
  localparam int ATANH_LUT [1:11] = '{9000, 4185, 2059, 1025, 512, 256, 128, 64, 32, 16, 8};

  // Angle for shift k; zero outside the table so an unused index is harmless
  function automatic logic [15:0] atanh_lut(input logic [3:0] k);
    atanh_lut = 16'd0;
    if (k >= 4'd1 && k <= 4'd11) begin
      atanh_lut = 16'(ATANH_LUT[k]);
    end
  endfunction

  // Hyperbolic schedule repeats k=4: cnt 0..3 -> 1..4, then cnt -> cnt
  function automatic logic [3:0] shift_of(input logic [3:0] cnt);
    shift_of = (cnt < 4'd4) ? cnt + 4'd1 : cnt;
  endfunction

endpackage

// File: rtl/cordic_atanh_if.sv
// rtl/cordic_atanh_if.sv - request/result bundle between a client and cordic_atanh
interface cordic_atanh_if;
  logic        start;
  logic [7:0]  tanh_in;
  logic        busy;
  logic        done;
  logic        sat;
  logic [15:0] atanh_out;

  modport master (
    output start, tanh_in,
    input  busy, done, sat, atanh_out
  );

  modport slave (
    input  start, tanh_in,
    output busy, done, sat, atanh_out
  );
endinterface

// File: rtl/cordic_atanh_hyp_stage.sv
// rtl/cordic_atanh_hyp_stage.sv - one combinational hyperbolic vectoring micro-rotation
module cordic_hyp_stage #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] x_i,
  input  logic signed [W-1:0] y_i,
  input  logic signed [W-1:0] z_i,
  input  logic        [3:0]   k_i,
  input  logic signed [W-1:0] lut_i,
  output logic signed [W-1:0] x_o,
  output logic signed [W-1:0] y_o,
  output logic signed [W-1:0] z_o
);

  logic signed [W-1:0] x_sh;
  logic signed [W-1:0] y_sh;

  // Rotate toward y=0: d=+1 when y is negative, else d=-1; z collects the angle
  always_comb begin
    x_sh = x_i >>> k_i;
    y_sh = y_i >>> k_i;
    if (y_i[W-1]) begin
      x_o = x_i + y_sh;
      y_o = y_i + x_sh;
      z_o = z_i - lut_i;
    end else begin
      x_o = x_i - y_sh;
      y_o = y_i - x_sh;
      z_o = z_i + lut_i;
    end
  end

endmodule

// File: rtl/cordic_atanh.sv
// rtl/cordic_atanh.sv - iterative hyperbolic CORDIC returning atanh of a Q1.7 code in Q8.8
module cordic_atanh
  import cordic_pkg::*;
#(
  parameter int N_ITER = 8,
  parameter int W      = 18
) (
  input  logic            clk,
  input  logic            reset,
  cordic_atanh_if.slave   bus
);

  localparam logic [3:0] LAST_CNT = 4'(N_ITER - 1);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic signed [W-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic                sat_r_q, sat_r_d;
  logic                busy_q, busy_d, done_q, done_d, sat_q, sat_d;
  logic [15:0]         out_q, out_d;

  logic signed [7:0]   code;
  logic signed [7:0]   clamped;
  logic                clip;
  logic signed [W-1:0] code_ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] rnd_sh;
  logic [3:0]          k_w;
  logic signed [W-1:0] lut_w, xs, ys, zs;

  assign k_w   = shift_of(cnt_q);
  assign lut_w = W'(atanh_lut(k_w));

  cordic_hyp_stage #(.W(W)) u_stage (
    .x_i   (x_q),
    .y_i   (y_q),
    .z_i   (z_q),
    .k_i   (k_w),
    .lut_i (lut_w),
    .x_o   (xs),
    .y_o   (ys),
    .z_o   (zs)
  );

  // Clamp to +-CLAMP_CODE so the angle stays inside the convergence range
  always_comb begin
    code    = $signed(bus.tanh_in);
    clamped = code;
    clip    = 1'b0;
    if (code > 8'sd102) begin
      clamped = 8'(CLAMP_CODE);
      clip    = 1'b1;
    end else if (code < -8'sd102) begin
      clamped = -8'sd102;
      clip    = 1'b1;
    end
    code_ext = {{(W-8){clamped[7]}}, clamped};
    rnd      = z_q + W'(32);
    rnd_sh   = rnd >>> 6;
  end

  // Next-state and datapath control for IDLE -> ITER -> FIN -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    sat_r_d = sat_r_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    sat_d   = sat_q;
    out_d   = out_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          x_d     = W'(ONE);
          y_d     = code_ext <<< 7;
          z_d     = '0;
          cnt_d   = 4'd0;
          sat_r_d = clip;
          busy_d  = 1'b1;
          state_d = ITER;
        end
      end
      ITER: begin
        x_d   = xs;
        y_d   = ys;
        z_d   = zs;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = FIN;
        end
      end
      FIN: begin
        out_d   = rnd_sh[15:0];
        sat_d   = sat_r_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight computation
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      sat_r_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sat_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      sat_r_q <= sat_r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sat_q   <= sat_d;
      out_q   <= out_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sat       = sat_q;
  assign bus.atanh_out = out_q;

endmodule

// File: tb/tb_cordic_atanh.sv
// tb/tb_cordic_atanh.sv - scoreboard bench for cordic_atanh
module tb_cordic_atanh;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cordic_atanh_if bus ();

  cordic_atanh #(.N_ITER(8), .W(18)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int   code;
    int   exp_out;
    logic exp_sat;
    int   due;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   mon_a;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   res [256];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name, input int act, input int exp_v);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  function automatic int clamp_code(input int c);
    if (c > 102) return 102;
    if (c < -102) return -102;
    return c;
  endfunction

  function automatic int ideal(input int c);
    real t, v;
    t = real'(clamp_code(c)) / 128.0;
    v = 128.0 * $ln((1.0 + t) / (1.0 - t));
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  // Called at a negedge with the DUT idle; expected result due 10 negedges later
  task automatic issue(input int code, input int exp_out);
    exp_t e;
    logic [31:0] cv;
    cv = code;
    bus.start   = 1'b1;
    bus.tanh_in = cv[7:0];
    e.code    = code;
    e.exp_out = exp_out;
    e.exp_sat = (clamp_code(code) != code);
    e.due     = cyc + 10;
    q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check(1'b0, "drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (q.size() == 0) begin
        check(1'b0, "unexpected_done", 1, 0);
      end else begin
        mon_e = q.pop_front();
        mon_a = int'($signed(bus.atanh_out));
        check((mon_a - mon_e.exp_out <= 2) && (mon_e.exp_out - mon_a <= 2),
              $sformatf("atanh_out code=%0d", mon_e.code), mon_a, mon_e.exp_out);
        check(bus.sat == mon_e.exp_sat, $sformatf("sat code=%0d", mon_e.code),
              int'(bus.sat), int'(mon_e.exp_sat));
        check(cyc == mon_e.due, $sformatf("latency code=%0d", mon_e.code), cyc, mon_e.due);
        res[mon_e.code & 255] = mon_a;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.tanh_in = 8'd0;
    repeat (3) @(negedge clk);
    check(bus.busy == 1'b0, "reset_busy", int'(bus.busy), 0);
    check(bus.done == 1'b0, "reset_done", int'(bus.done), 0);
    check(bus.sat == 1'b0, "reset_sat", int'(bus.sat), 0);
    check(bus.atanh_out == 16'd0, "reset_out", int'(bus.atanh_out), 0);
    reset = 1'b0;
    @(negedge clk);

    // Zero input, with busy window checked cycle by cycle
    issue(0, 0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      check(bus.busy == 1'b1, $sformatf("busy_high[%0d]", i), int'(bus.busy), 1);
    end
    @(negedge clk);
    check(bus.busy == 1'b0, "busy_low_at_done", int'(bus.busy), 0);
    drain();

    issue(64, 141);    drain();
    issue(-64, -141);  drain();
    issue(127, 279);   drain();
    issue(-128, -279); drain();

    // Start while busy is ignored; start in the done cycle is accepted
    issue(64, 141);
    repeat (2) @(negedge clk);
    bus.start   = 1'b1;
    bus.tanh_in = 8'd32;
    @(negedge clk);
    bus.start = 1'b0;
    check(bus.busy == 1'b1, "busy_during_ignored_start", int'(bus.busy), 1);
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    check(bus.done == 1'b1, "done_seen", int'(bus.done), 1);
    issue(32, 65);
    drain();

    // Reset mid-computation discards the result
    bus.start   = 1'b1;
    bus.tanh_in = 8'd64;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check(bus.busy == 1'b0, "midreset_busy", int'(bus.busy), 0);
    check(bus.done == 1'b0, "midreset_done", int'(bus.done), 0);
    check(bus.atanh_out == 16'd0, "midreset_out", int'(bus.atanh_out), 0);
    check(bus.sat == 1'b0, "midreset_sat", int'(bus.sat), 0);
    reset = 1'b0;
    repeat (14) @(negedge clk);
    issue(32, 65);
    drain();

    // Full code sweep against real atanh of the clamped code
    for (int c = 0; c < 256; c++) begin
      issue((c >= 128) ? c - 256 : c, ideal((c >= 128) ? c - 256 : c));
      drain();
    end
    check((res[64] + res[192] <= 1) && (res[64] + res[192] >= -1),
          "antisymmetry_64", res[64] + res[192], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
